// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670-style RGB565 stream transmitter.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } cam_state_e;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_SPLIT = 2'd2,
        PAT_GRAD  = 2'd3
    } cam_pat_e;

    localparam logic [15:0] RED565  = 16'hF800;
    localparam logic [15:0] BLUE565 = 16'h001F;

    localparam logic [15:0] BAR0_565 = 16'hFFFF;
    localparam logic [15:0] BAR1_565 = 16'hFFE0;
    localparam logic [15:0] BAR2_565 = 16'h07FF;
    localparam logic [15:0] BAR3_565 = 16'h07E0;
    localparam logic [15:0] BAR4_565 = 16'hF81F;
    localparam logic [15:0] BAR5_565 = 16'hF800;
    localparam logic [15:0] BAR6_565 = 16'h001F;
    localparam logic [15:0] BAR7_565 = 16'h0000;

    localparam int DEF_H_ACTIVE    = 176;
    localparam int DEF_V_ACTIVE    = 144;
    localparam int DEF_H_BLANK     = 32;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    function automatic logic [15:0] bar565(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR0_565;
            3'd1:    return BAR1_565;
            3'd2:    return BAR2_565;
            3'd3:    return BAR3_565;
            3'd4:    return BAR4_565;
            3'd5:    return BAR5_565;
            3'd6:    return BAR6_565;
            default: return BAR7_565;
        endcase
    endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// Camera-side bus: control/pattern inputs toward the transmitter and the DVP-style outputs.
interface cam_stream_tx_if;
    logic        ENABLE;
    logic [1:0]  PATTERN_SEL;
    logic [15:0] COLOR_IN;
    logic        PCLK_OUT;
    logic        VSYNC_OUT;
    logic        HREF_OUT;
    logic [7:0]  DATA_OUT;
    logic        FRAME_DONE;
    logic [7:0]  FRAME_CNT;

    modport master (
        input  ENABLE, PATTERN_SEL, COLOR_IN,
        output PCLK_OUT, VSYNC_OUT, HREF_OUT, DATA_OUT, FRAME_DONE, FRAME_CNT
    );

    modport slave (
        output ENABLE, PATTERN_SEL, COLOR_IN,
        input  PCLK_OUT, VSYNC_OUT, HREF_OUT, DATA_OUT, FRAME_DONE, FRAME_CNT
    );
endinterface

// File: rtl/cam_pattern_gen.sv
// Combinational RGB565 test-pattern source for the pixel currently being serialized.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [1:0]  pattern_sel_i,
    input  logic [15:0] color_i,
    input  logic [7:0]  x_pix_i,
    input  logic [5:0]  y_hi_i,
    input  logic [2:0]  bar_i,
    output logic [15:0] rgb_o
);
    localparam logic [7:0] HALF_X = 8'(H_ACTIVE / 2);

    always_comb begin
        rgb_o = color_i;
        case (cam_pat_e'(pattern_sel_i))
            PAT_SOLID: rgb_o = color_i;
            PAT_BARS:  rgb_o = bar565(bar_i);
            PAT_SPLIT: rgb_o = (x_pix_i < HALF_X) ? RED565 : BLUE565;
            // y_hi_i is y_line[7:2], so y_line[7:3] is its top five bits
            PAT_GRAD:  rgb_o = {x_pix_i[7:3], y_hi_i, x_pix_i[7:3] ^ y_hi_i[5:1]};
            default:   rgb_o = color_i;
        endcase
    end

endmodule

// File: rtl/cam_stream_tx.sv
// OV7670-style RGB565 transmitter: PCLK = CLOCK/2, frame FSM, byte serializer; all state advances on PCLK-high cycles.
module cam_stream_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input logic             CLOCK,
    input logic             RESET,
    cam_stream_tx_if.master bus
);
    localparam int          LP        = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES * LP - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK * LP - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT * LP - 1);
    localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [7:0]  V_LAST    = 8'(V_ACTIVE - 1);
    localparam int          BAR_W     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [7:0]  BAR_LAST  = 8'(BAR_W - 1);

    cam_state_e  state_q;
    logic        pclk_q, vsync_q, href_q, frame_done_q;
    logic [7:0]  data_q, frame_cnt_q;
    logic [15:0] slot_q;
    logic [7:0]  x_q, y_q, barcnt_q;
    logic [2:0]  bar_q;
    logic        phase_q, last_line_q;
    logic [1:0]  pat_q;
    logic [15:0] color_q;
    logic [15:0] pix_d;
    logic [7:0]  byte_d;

    cam_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .pattern_sel_i (pat_q),
        .color_i       (color_q),
        .x_pix_i       (x_q),
        .y_hi_i        (y_q[7:2]),
        .bar_i         (bar_q),
        .rgb_o         (pix_d)
    );

    // phase_q=0 selects the high byte, so every line starts on {R,G[5:3]}
    assign byte_d = phase_q ? pix_d[7:0] : pix_d[15:8];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'd0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            slot_q       <= 16'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            barcnt_q     <= 8'd0;
            bar_q        <= 3'd0;
            phase_q      <= 1'b0;
            last_line_q  <= 1'b0;
            pat_q        <= 2'd0;
            color_q      <= 16'd0;
        end else begin
            pclk_q       <= ~pclk_q;
            frame_done_q <= 1'b0;
            if (pclk_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.ENABLE) begin
                            state_q <= ST_VSYNC;
                            vsync_q <= 1'b1;
                            slot_q  <= 16'd0;
                            pat_q   <= bus.PATTERN_SEL;
                            color_q <= bus.COLOR_IN;
                        end
                    end
                    ST_VSYNC: begin
                        if (slot_q == VS_LAST) begin
                            state_q     <= ST_VBACK;
                            vsync_q     <= 1'b0;
                            slot_q      <= 16'd0;
                            y_q         <= 8'd0;
                            last_line_q <= 1'b0;
                            x_q         <= 8'd0;
                            phase_q     <= 1'b0;
                            bar_q       <= 3'd0;
                            barcnt_q    <= 8'd0;
                        end else begin
                            slot_q <= slot_q + 16'd1;
                        end
                    end
                    ST_VBACK: begin
                        if (slot_q == VB_LAST) begin
                            state_q <= ST_ACTIVE;
                            href_q  <= 1'b1;
                            data_q  <= byte_d;
                            phase_q <= 1'b1;
                            slot_q  <= 16'd0;
                        end else begin
                            slot_q <= slot_q + 16'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (slot_q == LINE_LAST) begin
                            state_q  <= ST_HBLANK;
                            href_q   <= 1'b0;
                            data_q   <= 8'd0;
                            slot_q   <= 16'd0;
                            x_q      <= 8'd0;
                            phase_q  <= 1'b0;
                            bar_q    <= 3'd0;
                            barcnt_q <= 8'd0;
                            // advance y here so the next line's first byte already sees it
                            if (y_q == V_LAST) last_line_q <= 1'b1;
                            else               y_q         <= y_q + 8'd1;
                        end else begin
                            slot_q  <= slot_q + 16'd1;
                            data_q  <= byte_d;
                            phase_q <= ~phase_q;
                            if (phase_q) begin
                                x_q <= x_q + 8'd1;
                                if (barcnt_q == BAR_LAST) begin
                                    barcnt_q <= 8'd0;
                                    if (bar_q != 3'd7) bar_q <= bar_q + 3'd1;
                                end else begin
                                    barcnt_q <= barcnt_q + 8'd1;
                                end
                            end
                        end
                    end
                    ST_HBLANK: begin
                        if (slot_q == HB_LAST) begin
                            slot_q <= 16'd0;
                            if (last_line_q) begin
                                state_q <= ST_VFRONT;
                            end else begin
                                state_q <= ST_ACTIVE;
                                href_q  <= 1'b1;
                                data_q  <= byte_d;
                                phase_q <= 1'b1;
                            end
                        end else begin
                            slot_q <= slot_q + 16'd1;
                        end
                    end
                    ST_VFRONT: begin
                        if (slot_q == VF_LAST) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                            slot_q       <= 16'd0;
                            if (bus.ENABLE) begin
                                state_q <= ST_VSYNC;
                                vsync_q <= 1'b1;
                                pat_q   <= bus.PATTERN_SEL;
                                color_q <= bus.COLOR_IN;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            slot_q <= slot_q + 16'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.PCLK_OUT   = pclk_q;
    assign bus.VSYNC_OUT  = vsync_q;
    assign bus.HREF_OUT   = href_q;
    assign bus.DATA_OUT   = data_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.FRAME_CNT  = frame_cnt_q;

endmodule
